// File: rtl/axi_irig_frame_fifo_if.sv
// AXI4-Lite slave bus and IRIG decoder AXI-Stream input
// bundled for the frame FIFO.
interface axi_irig_frame_fifo_if #(
  parameter int DATA_W     = 164,
  parameter int AXI_ADDR_W = 6
);
  logic [AXI_ADDR_W-1:0] s_axi_awaddr;
  logic [2:0]            s_axi_awprot;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [AXI_ADDR_W-1:0] s_axi_araddr;
  logic [2:0]            s_axi_arprot;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;
  logic [DATA_W-1:0]     s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready
  );

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready
  );
endinterface

// File: rtl/axi_irig_frame_fifo.sv
// Queued IRIG frame reader: DEPTH-entry FIFO drained over
// AXI4-Lite, with pop/flush control, overflow sticky and drop count.
module axi_irig_frame_fifo #(
  parameter int DATA_W     = 164,
  parameter int DEPTH      = 4,
  parameter int OVERWRITE  = 1,
  parameter int AXI_ADDR_W = 6
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_areset,
  axi_irig_frame_fifo_if.slave bus,
  output logic                 irq
);
  localparam int NWORDS = (DATA_W + 31) / 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WA_W   = AXI_ADDR_W - 2;
  localparam bit OVW    = (OVERWRITE != 0);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [15:0]       r_drop;
  logic              r_awready;
  logic              r_bvalid;
  logic              r_arready;
  logic              r_rvalid;
  logic [31:0]       r_rdata;
  logic              r_irq;

  logic              w_aw_go;
  logic              w_wr_hs;
  logic              w_ar_go;
  logic              w_rd_hs;
  logic              w_ctrl;
  logic              w_not_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_clr;
  logic              w_flush;
  logic              w_ovf;
  logic              w_wr_mem;
  logic [WA_W-1:0]   w_aw_word;
  logic [WA_W-1:0]   w_ar_word;
  logic [DATA_W-1:0] w_head;
  logic [NWORDS*32-1:0] w_head_pad;
  logic [31:0]       w_status;
  logic [31:0]       w_rmux;
  logic              w_unused;

  assign w_aw_word = bus.s_axi_awaddr[AXI_ADDR_W-1:2];
  assign w_ar_word = bus.s_axi_araddr[AXI_ADDR_W-1:2];

  assign w_aw_go = bus.s_axi_awvalid & bus.s_axi_wvalid
                 & ~r_bvalid & ~r_awready;
  assign w_wr_hs = r_awready & bus.s_axi_awvalid
                 & bus.s_axi_wvalid;
  assign w_ar_go = bus.s_axi_arvalid & ~r_arready & ~r_rvalid;
  assign w_rd_hs = r_arready & bus.s_axi_arvalid;

  assign w_ctrl      = w_wr_hs & (w_aw_word == WA_W'(1));
  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == FULL);
  assign w_push      = bus.s_axis_tvalid;
  assign w_pop       = w_ctrl & bus.s_axi_wdata[0] & w_not_empty;
  assign w_clr       = w_ctrl & bus.s_axi_wdata[1];
  assign w_flush     = w_ctrl & bus.s_axi_wdata[2];
  // a pop frees a slot, so only an unmatched push into a full FIFO drops
  assign w_ovf       = w_push & ~w_pop & w_full & ~w_flush;
  assign w_wr_mem    = w_push & (~w_ovf | OVW);
  assign w_head      = r_mem[r_rd_ptr];

  assign bus.s_axi_awready = r_awready;
  assign bus.s_axi_wready  = r_awready;
  assign bus.s_axi_bvalid  = r_bvalid;
  assign bus.s_axi_bresp   = 2'b00;
  assign bus.s_axi_arready = r_arready;
  assign bus.s_axi_rvalid  = r_rvalid;
  assign bus.s_axi_rdata   = r_rdata;
  assign bus.s_axi_rresp   = 2'b00;
  assign bus.s_axis_tready = 1'b1;
  assign irq               = r_irq;

  assign w_unused = ^{bus.s_axi_awprot, bus.s_axi_arprot,
                      bus.s_axi_wstrb, bus.s_axi_wdata[31:3],
                      bus.s_axi_awaddr[1:0],
                      bus.s_axi_araddr[1:0]};

  // frame storage, written at the tail
  always_ff @(posedge s_axi_aclk) begin
    if (w_wr_mem) r_mem[r_wr_ptr] <= bus.s_axis_tdata;
  end

  // pointers and occupancy
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= w_push ? CNT_W'(1) : '0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end else begin
      if (w_pop | (w_ovf & OVW))
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr_mem)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_push & ~w_pop & ~w_full)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop & ~w_push)
        r_count <= r_count - CNT_W'(1);
    end
  end

  // overflow sticky and saturating drop counter; an event beats clear
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_ovf) begin
      r_ovf  <= 1'b1;
      if (w_clr)
        r_drop <= 16'd1;
      else if (r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;
    end else if (w_clr) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end
  end

  // interrupt follows not_empty one cycle later
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_irq <= 1'b0;
    else              r_irq <= w_not_empty;
  end

  // write address/data accept and single-beat response
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= w_aw_go;
      if (w_wr_hs)
        r_bvalid <= 1'b1;
      else if (bus.s_axi_bready)
        r_bvalid <= 1'b0;
    end
  end

  // status word layout
  always_comb begin
    w_status = '0;
    w_status[0] = w_not_empty;
    w_status[CNT_W+7:8] = r_count;
    w_status[16] = r_ovf;
    w_status[31:24] = 8'(DEPTH);
  end

  // read data select, head words zero-padded
  always_comb begin
    w_head_pad = '0;
    w_head_pad[DATA_W-1:0] = w_head;
    w_rmux = '0;
    if (w_ar_word == '0)
      w_rmux = w_status;
    else if (w_ar_word == WA_W'(1))
      w_rmux = {16'h0, r_drop};
    else if (w_not_empty)
      for (int k = 0; k < NWORDS; k++)
        if (w_ar_word == WA_W'(k + 2))
          w_rmux = w_head_pad[k*32 +: 32];
  end

  // read accept; data frozen at handshake until rready
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_ar_go;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rmux;
      end else if (bus.s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule
